// File: rtl/isqrt_256b_seq.sv
// isqrt_256b_seq: sequential restoring square root, one root bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : radicand handshake (in_ready only in IDLE)
//   radicand [RAD_W]    : unsigned operand, captured on the accept edge
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   root [ROOT_W]       : floor(sqrt(radicand))
//   remainder [ROOT_W+1]: radicand - root^2
//   busy                : high in RUN or DONE
module isqrt_256b_seq #(
  parameter  int RAD_W  = 256,
  localparam int ROOT_W = RAD_W / 2,
  localparam int CNT_W  = $clog2(ROOT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RAD_W-1:0]  radicand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root,
  output logic [ROOT_W:0]   remainder,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [RAD_W-1:0]    sr_q, sr_d;
  logic [ROOT_W:0]     rem_q, rem_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Trial values. During RUN the partial root is below 2^(ROOT_W-1) and
  // rem <= 2*root, so rem_q[ROOT_W] is zero and the shifted remainder fits
  // in ROOT_W+2 bits without losing anything.
  logic [ROOT_W+1:0]   r_try;
  logic [ROOT_W+1:0]   t_try;
  logic                ge;

  assign r_try = {rem_q[ROOT_W-1:0], sr_q[RAD_W-1 -: 2]};
  assign t_try = {root_q, 2'b01};
  assign ge    = (r_try >= t_try);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = radicand;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_W'(ROOT_W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d   = {sr_q[RAD_W-3:0], 2'b00};
        rem_d  = ge ? (ROOT_W+1)'(r_try - t_try) : r_try[ROOT_W:0];
        root_d = {root_q[ROOT_W-2:0], ge};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign root      = root_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_isqrt_256b_seq.sv
// Directed and small random checks for isqrt_256b_seq (defaults RAD_W=256).
module tb_isqrt_256b_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] radicand = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] root;
  logic [128:0] remainder;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  isqrt_256b_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .radicand(radicand),
    .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder), .busy(busy)
  );

  typedef struct {
    logic [255:0] rad;
    logic [127:0] exp_root;
    logic [128:0] exp_rem;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Present one radicand and wait for out_valid; lat = edges after accept.
  task automatic do_op(input logic [255:0] rad, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    radicand = rad;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_in_ready", 256'(in_ready), 256'd1);
    chk("drain_out_valid", 256'(out_valid), 256'd0);
  endtask

  initial begin
    vec_t vecs[14];
    logic [255:0] ones128;
    logic [127:0] r_hold;
    logic [128:0] m_hold;
    int lat;

    ones128 = {128'd0, {128{1'b1}}};
    vecs[0]  = '{256'd0,       128'd0,    129'd0};
    vecs[1]  = '{256'd1,       128'd1,    129'd0};
    vecs[2]  = '{256'd2,       128'd1,    129'd1};
    vecs[3]  = '{256'd3,       128'd1,    129'd2};
    vecs[4]  = '{256'd8,       128'd2,    129'd4};
    vecs[5]  = '{256'd25,      128'd5,    129'd0};
    vecs[6]  = '{256'd26,      128'd5,    129'd1};
    vecs[7]  = '{256'd99,      128'd9,    129'd18};
    vecs[8]  = '{256'd1000000, 128'd1000, 129'd0};
    vecs[9]  = '{256'd144,     128'd12,   129'd0};
    vecs[10] = '{{256{1'b1}}, {128{1'b1}}, {{128{1'b1}}, 1'b0}};
    vecs[11] = '{ones128 * ones128, {128{1'b1}}, 129'd0};
    vecs[12] = '{256'd1 << 254, 128'd1 << 127, 129'd0};
    vecs[13] = '{(256'd1 << 254) - 256'd1, (128'd1 << 127) - 128'd1,
                 (129'd1 << 128) - 129'd2};

    // Reset state (asynchronous, checked while rst_n is low).
    #2;
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_root", 256'(root), 256'd0);
    chk("rst_rem", 256'(remainder), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].rad, lat);
      chk($sformatf("lat[%0d]", i), 256'(lat), 256'd128);
      chk($sformatf("root[%0d]", i), 256'(root), 256'(vecs[i].exp_root));
      chk($sformatf("rem[%0d]", i), 256'(remainder), 256'(vecs[i].exp_rem));
      drain();
    end

    // Backpressure: result held, in_valid ignored, release drains next edge.
    do_op(256'd26, lat);
    r_hold = root;
    m_hold = remainder;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      radicand = 256'd9;
      @(posedge clk); #1;
      chk("bp_out_valid", 256'(out_valid), 256'd1);
      chk("bp_in_ready", 256'(in_ready), 256'd0);
      chk("bp_busy", 256'(busy), 256'd1);
      chk("bp_root", 256'(root), 256'(r_hold));
      chk("bp_rem", 256'(remainder), 256'(m_hold));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("post_drain_root", 256'(root), 256'd5);
    chk("post_drain_busy", 256'(busy), 256'd0);

    // Reset in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1;
    radicand = {256{1'b1}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 256'(in_ready), 256'd1);
    chk("mid_rst_out_valid", 256'(out_valid), 256'd0);
    chk("mid_rst_root", 256'(root), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(256'd144, lat);
    chk("after_rst_lat", 256'(lat), 256'd128);
    chk("after_rst_root", 256'(root), 256'd12);
    chk("after_rst_rem", 256'(remainder), 256'd0);
    drain();

    // Random sums of squares with random output stalls; checked against the
    // defining properties of a floor square root.
    for (int k = 0; k < 20; k++) begin
      logic [255:0] a, b, rad, sq;
      a = 256'({$urandom, $urandom, $urandom, $urandom} & {1'b0, {127{1'b1}}});
      b = 256'({$urandom, $urandom, $urandom, $urandom} & {1'b0, {127{1'b1}}});
      rad = a * a + b * b;
      do_op(rad, lat);
      chk("rnd_lat", 256'(lat), 256'd128);
      r_hold = root;
      m_hold = remainder;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_stall_root", 256'(root), 256'(r_hold));
      end
      sq = 256'(root) * 256'(root);
      chk("rnd_sq_plus_rem", sq + 256'(remainder), rad);
      chk("rnd_rem_le_2root", 256'(257'(remainder) <= 257'(root) * 257'd2), 256'd1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
